// File: rtl/pciecfg_arbiter.sv
// pciecfg_arbiter
//   Shares the PCIe hard-IP cfg_mgmt port between NREQ requesters. Requests
//   are granted round-robin and one cfg_mgmt read or write runs at a time. Each
//   access waits for cfg_mgmt_rd_wr_done, or gives up after TIMEOUT enable
//   cycles. The result goes back to the requester that owns the access as a
//   one-cycle rsp_valid pulse.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (req_ready is combinational)
//   req_wr                1 = write, 0 = read
//   req_dwaddr            10-bit DW address per requester, packed
//   req_byte_en           4-bit byte enables per requester, packed
//   req_wdata             32-bit write data per requester, packed
//   rsp_valid             one-hot completion pulse to the owning requester
//   rsp_rdata             read data (0xFFFFFFFF on timeout), shared
//   rsp_timeout           access timed out, valid with rsp_valid
//   busy                  an access or its response cycle is in progress
//   cfg_mgmt_*            connection to the PCIe core management port
module pciecfg_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_wr,
  input  logic [NREQ*10-1:0] req_dwaddr,
  input  logic [NREQ*4-1:0] req_byte_en,
  input  logic [NREQ*32-1:0] req_wdata,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [9:0]        cfg_mgmt_dwaddr,
  output logic              cfg_mgmt_rd_en,
  output logic              cfg_mgmt_wr_en,
  output logic [3:0]        cfg_mgmt_byte_en,
  output logic [31:0]       cfg_mgmt_di,
  input  logic [31:0]       cfg_mgmt_do,
  input  logic              cfg_mgmt_rd_wr_done
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [LW-1:0]   r_last;
  logic [TW-1:0]   r_timer;
  logic            r_wr;
  logic [9:0]      r_dwaddr;
  logic [3:0]      r_byte_en;
  logic [31:0]     r_wdata;
  logic            r_rd_en;
  logic            r_wr_en;
  logic [NREQ-1:0] r_rsp_valid;
  logic [31:0]     r_rsp_rdata;
  logic            r_rsp_timeout;

  logic            w_found;
  logic [LW-1:0]   w_grant;
  logic            w_xfer;
  logic            w_expire;
  logic [NREQ-1:0] w_last_oh;
  logic            w_sel_wr;
  logic [9:0]      w_sel_dwaddr;
  logic [3:0]      w_sel_byte_en;
  logic [31:0]     w_sel_wdata;

  // Round-robin search starting one past the last granted requester, so the
  // requester just served has the lowest priority next time.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_grant = '0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(r_last) + k) % NREQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_grant = LW'(idx);
      end
    end
  end

  // req_ready is masked by rst_n so nothing is accepted while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && (r_state == S_IDLE) && w_found) begin
      req_ready[w_grant] = 1'b1;
    end
  end

  assign w_xfer        = rst_n && (r_state == S_IDLE) && w_found;
  assign w_expire      = (r_timer == TW'(TIMEOUT - 1));
  assign w_sel_wr      = req_wr[w_grant];
  assign w_sel_dwaddr  = req_dwaddr[int'(w_grant)*10 +: 10];
  assign w_sel_byte_en = req_byte_en[int'(w_grant)*4 +: 4];
  assign w_sel_wdata   = req_wdata[int'(w_grant)*32 +: 32];

  // r_last holds the grant of the access in flight, so it also addresses
  // the response.
  always_comb begin
    w_last_oh         = '0;
    w_last_oh[r_last] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_xfer) w_state_nxt = S_ACCESS;
      S_ACCESS: if (cfg_mgmt_rd_wr_done || w_expire) w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last        <= LW'(NREQ - 1);
      r_timer       <= '0;
      r_wr          <= 1'b0;
      r_dwaddr      <= '0;
      r_byte_en     <= '0;
      r_wdata       <= '0;
      r_rd_en       <= 1'b0;
      r_wr_en       <= 1'b0;
      r_rsp_valid   <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_last    <= w_grant;
            r_timer   <= '0;
            r_wr      <= w_sel_wr;
            r_dwaddr  <= w_sel_dwaddr;
            // Reads never drive byte enables into the core.
            r_byte_en <= w_sel_wr ? w_sel_byte_en : 4'h0;
            r_wdata   <= w_sel_wdata;
            r_rd_en   <= !w_sel_wr;
            r_wr_en   <= w_sel_wr;
          end
        end
        S_ACCESS: begin
          // done is checked first so it wins over a simultaneous expiry.
          if (cfg_mgmt_rd_wr_done) begin
            r_rd_en       <= 1'b0;
            r_wr_en       <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= w_last_oh;
            if (!r_wr) begin
              r_rsp_rdata <= cfg_mgmt_do;
            end
          end else if (w_expire) begin
            r_rd_en       <= 1'b0;
            r_wr_en       <= 1'b0;
            r_rsp_timeout <= 1'b1;
            r_rsp_rdata   <= 32'hFFFF_FFFF;
            r_rsp_valid   <= w_last_oh;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy             = (r_state != S_IDLE);
  assign rsp_valid        = r_rsp_valid;
  assign rsp_rdata        = r_rsp_rdata;
  assign rsp_timeout      = r_rsp_timeout;
  assign cfg_mgmt_dwaddr  = r_dwaddr;
  assign cfg_mgmt_rd_en   = r_rd_en;
  assign cfg_mgmt_wr_en   = r_wr_en;
  assign cfg_mgmt_byte_en = r_byte_en;
  assign cfg_mgmt_di      = r_wdata;

endmodule

// File: tb/tb_pciecfg_arbiter.sv
// Testbench for pciecfg_arbiter (NREQ=2, TIMEOUT=16). A table of single
// transactions is applied in a loop. Hand-written sequences cover reset
// state, round-robin arbitration and an asynchronous reset mid-access.
module tb_pciecfg_arbiter;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 16;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_wr;
  logic [NREQ*10-1:0] req_dwaddr;
  logic [NREQ*4-1:0] req_byte_en;
  logic [NREQ*32-1:0] req_wdata;
  logic [NREQ-1:0]   rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_timeout;
  logic              busy;
  logic [9:0]        cfg_mgmt_dwaddr;
  logic              cfg_mgmt_rd_en;
  logic              cfg_mgmt_wr_en;
  logic [3:0]        cfg_mgmt_byte_en;
  logic [31:0]       cfg_mgmt_di;
  logic [31:0]       cfg_mgmt_do;
  logic              cfg_mgmt_rd_wr_done;

  pciecfg_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_wr              (req_wr),
    .req_dwaddr          (req_dwaddr),
    .req_byte_en         (req_byte_en),
    .req_wdata           (req_wdata),
    .rsp_valid           (rsp_valid),
    .rsp_rdata           (rsp_rdata),
    .rsp_timeout         (rsp_timeout),
    .busy                (busy),
    .cfg_mgmt_dwaddr     (cfg_mgmt_dwaddr),
    .cfg_mgmt_rd_en      (cfg_mgmt_rd_en),
    .cfg_mgmt_wr_en      (cfg_mgmt_wr_en),
    .cfg_mgmt_byte_en    (cfg_mgmt_byte_en),
    .cfg_mgmt_di         (cfg_mgmt_di),
    .cfg_mgmt_do         (cfg_mgmt_do),
    .cfg_mgmt_rd_wr_done (cfg_mgmt_rd_wr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          rq;
    logic        wr;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          done_at;   // enable cycle on which done is raised, 0 = never
    logic [31:0] do_val;
    int          exp_en;    // expected number of enable-high cycles
    logic [3:0]  exp_be;
    logic [1:0]  exp_rv;
    logic [31:0] exp_rdata;
    logic        exp_to;
  } txn_t;

  int n_cmp;
  int n_fail;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input txn_t t, input string tag);
    bit          got;
    int          en_cnt;
    bit          stable;
    logic [9:0]  a0;
    logic [3:0]  b0;
    logic [31:0] d0;
    logic [1:0]  e0;
    req_wr[t.rq]               = t.wr;
    req_dwaddr[t.rq*10 +: 10]  = t.addr;
    req_byte_en[t.rq*4 +: 4]   = t.be;
    req_wdata[t.rq*32 +: 32]   = t.wd;
    req_valid[t.rq]            = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (req_ready[t.rq]) got = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_accept"}, {31'd0, got}, 32'd1);
    if (!got) begin
      req_valid[t.rq] = 1'b0;
      return;
    end
    check({tag, "_ready"}, {30'd0, req_ready}, 32'(1 << t.rq));
    @(negedge clk); #1;
    req_valid[t.rq] = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    en_cnt = 0;
    stable = 1'b1;
    a0 = '0; b0 = '0; d0 = '0; e0 = '0;
    while ((cfg_mgmt_rd_en || cfg_mgmt_wr_en) && en_cnt < 64) begin
      en_cnt++;
      if (en_cnt == 1) begin
        a0 = cfg_mgmt_dwaddr; b0 = cfg_mgmt_byte_en; d0 = cfg_mgmt_di;
        e0 = {cfg_mgmt_rd_en, cfg_mgmt_wr_en};
      end else if (a0 !== cfg_mgmt_dwaddr || b0 !== cfg_mgmt_byte_en ||
                   d0 !== cfg_mgmt_di || e0 !== {cfg_mgmt_rd_en, cfg_mgmt_wr_en}) begin
        stable = 1'b0;
      end
      cfg_mgmt_do         = t.do_val;
      cfg_mgmt_rd_wr_done = (en_cnt == t.done_at);
      @(negedge clk); #1;
    end
    cfg_mgmt_rd_wr_done = 1'b0;
    check({tag, "_en_cycles"}, en_cnt, t.exp_en);
    check({tag, "_en_kind"}, {30'd0, e0}, t.wr ? 32'd1 : 32'd2);
    check({tag, "_dwaddr"}, {22'd0, a0}, {22'd0, t.addr});
    check({tag, "_byte_en"}, {28'd0, b0}, {28'd0, t.exp_be});
    check({tag, "_di"}, d0, t.wd);
    check({tag, "_stable"}, {31'd0, stable}, 32'd1);
    check({tag, "_rsp_valid"}, {30'd0, rsp_valid}, {30'd0, t.exp_rv});
    check({tag, "_rdata"}, rsp_rdata, t.exp_rdata);
    check({tag, "_timeout"}, {31'd0, rsp_timeout}, {31'd0, t.exp_to});
    @(negedge clk); #1;
    check({tag, "_rsp_clear"}, {30'd0, rsp_valid}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  txn_t tbl [6];
  txn_t tx;
  int   exp_order [4];

  initial begin
    int grants;
    int last_cyc;
    int g;
    int n;
    logic [NREQ-1:0] seen_rv;
    n_cmp = 0;
    n_fail = 0;

    //          rq wr  addr    be    wdata          done  do_val         en  exp_be rv     rdata          to
    tbl[0] = '{0, 1'b0, 10'h004, 4'hF, 32'h0,         3,  32'h10EE7024,  3, 4'h0, 2'b01, 32'h10EE7024, 1'b0};
    tbl[1] = '{1, 1'b1, 10'h001, 4'hF, 32'hDEADBEEF,  1,  32'h12345678,  1, 4'hF, 2'b10, 32'h10EE7024, 1'b0};
    tbl[2] = '{0, 1'b0, 10'h0AB, 4'h0, 32'h0,         0,  32'h55555555, 16, 4'h0, 2'b01, 32'hFFFFFFFF, 1'b1};
    tbl[3] = '{1, 1'b0, 10'h3FF, 4'h0, 32'h0,         1,  32'hCAFEF00D,  1, 4'h0, 2'b10, 32'hCAFEF00D, 1'b0};
    tbl[4] = '{0, 1'b0, 10'h120, 4'h0, 32'h0,        16,  32'h0BADC0DE, 16, 4'h0, 2'b01, 32'h0BADC0DE, 1'b0};
    tbl[5] = '{1, 1'b1, 10'h200, 4'h3, 32'h11223344,  2,  32'h99999999,  2, 4'h3, 2'b10, 32'h0BADC0DE, 1'b0};
    exp_order = '{0, 1, 0, 1};

    rst_n               = 1'b0;
    req_valid           = 2'b11;
    req_wr              = '0;
    req_dwaddr          = '0;
    req_byte_en         = '0;
    req_wdata           = '0;
    cfg_mgmt_do         = '0;
    cfg_mgmt_rd_wr_done = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", {30'd0, req_ready}, 32'd0);
    check("rst_rd_en", {31'd0, cfg_mgmt_rd_en}, 32'd0);
    check("rst_wr_en", {31'd0, cfg_mgmt_wr_en}, 32'd0);
    check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_timeout", {31'd0, rsp_timeout}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Both requesters held valid from reset release: 0,1,0,1 every 3 cycles.
    rst_n = 1'b1;
    #1;
    grants = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 60 && grants < 4; cyc++) begin
      if (req_ready != '0) begin
        check("arb_onehot", $countones(req_ready), 1);
        g = req_ready[1] ? 1 : 0;
        check($sformatf("arb_order%0d", grants), g, exp_order[grants]);
        if (grants > 0) check($sformatf("arb_gap%0d", grants), cyc - last_cyc, 3);
        last_cyc = cyc;
        grants++;
      end
      cfg_mgmt_rd_wr_done = cfg_mgmt_rd_en | cfg_mgmt_wr_en;
      @(negedge clk); #1;
    end
    check("arb_count", grants, 4);
    req_valid = '0;
    n = 0;
    while (busy && n < 50) begin
      cfg_mgmt_rd_wr_done = cfg_mgmt_rd_en | cfg_mgmt_wr_en;
      @(negedge clk); #1;
      n++;
    end
    cfg_mgmt_rd_wr_done = 1'b0;
    check("arb_drain", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i], $sformatf("tbl%0d", i));
    end

    // Asynchronous reset during a read that never completes.
    req_wr[0] = 1'b0;
    req_dwaddr[9:0] = 10'h010;
    req_valid[0] = 1'b1;
    n = 0;
    #1;
    while (!req_ready[0] && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check("abort_accept", {31'd0, req_ready[0]}, 32'd1);
    @(negedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk); #1;
    check("abort_pre_en", {31'd0, cfg_mgmt_rd_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_en_drop", {30'd0, cfg_mgmt_rd_en, cfg_mgmt_wr_en}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    seen_rv = '0;
    repeat (2) begin
      @(negedge clk); #1;
      seen_rv |= rsp_valid;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk); #1;
      seen_rv |= rsp_valid;
    end
    check("abort_no_rsp", {30'd0, seen_rv}, 32'd0);
    tx = '{1, 1'b1, 10'h155, 4'hC, 32'hA5A55A5A, 2, 32'h77777777, 2, 4'hC, 2'b10, 32'h0, 1'b0};
    run_txn(tx, "post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pciecfg_arbiter.md
# pciecfg_arbiter

Shares the single PCIe hard-IP configuration management port (cfg_mgmt_*) between NREQ independent requesters, such as the host-driven config-access FIFO path and on-board init or monitoring sequencers. It grants requesters round-robin and runs one read or write at a time. It waits for cfg_mgmt_rd_wr_done, bounded by a timeout, and returns read data and status to the granted requester. It sits between the requester logic and the PCIe core's cfg_mgmt interface.

## Interface
- NREQ, 2, number of requesters (2..8)
- TIMEOUT, 1024, maximum cycles an access waits for cfg_mgmt_rd_wr_done (≥2)

- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  NREQ  request pending, held until accepted
- req_ready  out  NREQ  accept strobe; transfer when req_valid[i] && req_ready[i]
- req_wr  in  NREQ  1 = write, 0 = read
- req_dwaddr  in  NREQ*10  DW address, requester i at [10i+9:10i]
- req_byte_en  in  NREQ*4  write byte enables, requester i at [4i+3:4i]
- req_wdata  in  NREQ*32  write data, requester i at [32i+31:32i]
- rsp_valid  out  NREQ  one-cycle completion pulse to the owning requester
- rsp_rdata  out  32  read data; shared, valid with rsp_valid
- rsp_timeout  out  1  access timed out; valid with rsp_valid
- busy  out  1  state != IDLE
- cfg_mgmt_dwaddr  out  10
- cfg_mgmt_rd_en  out  1
- cfg_mgmt_wr_en  out  1
- cfg_mgmt_byte_en  out  4
- cfg_mgmt_di  out  32
- cfg_mgmt_do  in  32
- cfg_mgmt_rd_wr_done  in  1

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Grant g is the first requester with req_valid set, searching upward from (last+1) mod NREQ.
  - req_ready is combinational: one-hot at g, and only in IDLE.
  - On transfer: latch addr, byte_en (forced to 0 for reads), wdata and wr; set last<=g; clear timer; assert cfg_mgmt_rd_en or cfg_mgmt_wr_en (registered); go to ACCESS.
- ACCESS:
  - The enable stays high, with cfg_mgmt_dwaddr, byte_en and di held constant.
  - If cfg_mgmt_rd_wr_done: drop the enable, set rsp_rdata<=cfg_mgmt_do (reads; writes leave it unchanged), rsp_timeout<=0, rsp_valid<=onehot(g); go to RESP.
  - Else if timer==TIMEOUT-1: drop the enable, set rsp_rdata<=32'hFFFF_FFFF, rsp_timeout<=1, rsp_valid<=onehot(g); go to RESP.
  - Else timer+1. The timer is $clog2(TIMEOUT) bits.
- RESP: go to IDLE. rsp_valid clears by default every cycle.
- Reset: state=IDLE, last=NREQ-1 (requester 0 has first priority), timer=0, every registered output 0. req_ready is forced to 0 while rst_n is low.

## Timing
- Transfer at cycle T. Enable is high from T+1.
- done sampled at T+1+k (k≥0): the enable is high for k+1 cycles. rsp_valid, rsp_rdata and rsp_timeout are valid at T+2+k. RESP occupies T+2+k. The next transfer is possible at T+3+k.
- This guarantees at least 2 cycles of enable low between consecutive cfg_mgmt accesses.
- Timeout: the enable is high exactly TIMEOUT cycles. rsp_valid follows the next cycle.
- done and timer expiry in the same cycle: done wins, rsp_timeout=0.
- done while in IDLE or RESP: ignored.
- Requesters must keep req_* stable while req_valid is high and not yet accepted. A requester may drop req_valid before acceptance; no transfer occurs.
- Simultaneous requests are served strictly round-robin. No requester waits more than NREQ-1 other accesses.
- Async reset mid-ACCESS: enables drop to 0 immediately. No rsp_valid is produced for the aborted access. Normal operation resumes from IDLE after release.

## Test plan
- Read: req0 reads dwaddr 0x004; the model asserts done on the 3rd enable cycle with do=0x10EE7024 -> rd_en high 3 cycles, wr_en 0, byte_en 0, rsp_valid=2'b01 for one cycle with rsp_rdata=0x10EE7024, rsp_timeout=0.
- Write: req1 writes dwaddr 0x001, byte_en 0xF, data 0xDEADBEEF; done on the 1st cycle -> wr_en high 1 cycle with dwaddr=0x001, di=0xDEADBEEF, byte_en=0xF; rsp_valid=2'b10.
- Arbitration: from reset, both requesters keep req_valid high for 4 accesses -> grant order 0,1,0,1. Each subsequent req_ready comes 3+k cycles after the previous one.
- Timeout: TIMEOUT=16, done never asserted -> rd_en high exactly 16 cycles, then rsp_timeout=1, rsp_rdata=0xFFFFFFFF. A following read completes normally with rsp_timeout=0.
- Collision: TIMEOUT=16, done asserted on the 16th enable cycle -> normal response with rsp_timeout=0 and rdata from cfg_mgmt_do.
- Reset abort: deassert rst_n during ACCESS -> rd_en/wr_en 0 in the same cycle, no rsp_valid. After release, a req1 write completes normally.
